sr_latch_monitor: RTL

//  Synchronous checker on the far side of an SR latch's stimulus: observes the s/r

---
 rtl/sr_latch_monitor_if.sv | 26 ++
 rtl/sr_latch_monitor.sv | 91 +++++++++
 2 files changed

// File: rtl/sr_latch_monitor_if.sv
// sr_latch_monitor_if: observation and result signals between an SR latch under test and its monitor
//   master: drives s, r, q, notq, clr; receives model/flag/counter results
//   slave : monitor side; receives latch signals, drives results
interface sr_latch_monitor_if #(parameter int CW = 8);
    logic          s;
    logic          r;
    logic          q;
    logic          notq;
    logic          clr;
    logic          exp_q;
    logic          exp_valid;
    logic          mismatch;
    logic          forbidden;
    logic [CW-1:0] n_set;
    logic [CW-1:0] n_reset;
    logic [CW-1:0] n_err;
    logic [1:0]    state;
    modport master (
        output s, r, q, notq, clr,
        input  exp_q, exp_valid, mismatch, forbidden, n_set, n_reset, n_err, state
    );
    modport slave (
        input  s, r, q, notq, clr,
        output exp_q, exp_valid, mismatch, forbidden, n_set, n_reset, n_err, state
    );
endinterface

// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: reference model and checker for an SR latch observed through synchronizers
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport; s/r/q/notq/clr in, exp_q/exp_valid/mismatch/forbidden,
//           n_set/n_reset/n_err (saturating) and state (0 UNKNOWN,1 SETTLE,2 CHECK,3 FORBID) out
module sr_latch_monitor #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CW            = 8
) (
    input logic             clk,
    input logic             rst_n,
    sr_latch_monitor_if.slave bus
);
    typedef enum logic [1:0] {UNKNOWN, SETTLE, CHECK, FORBID} state_t;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    state_t        st;
    logic [1:0]    s_sync, r_sync, q_sync, nq_sync, p_prev;
    logic [SW-1:0] cnt;
    logic          exp_q, mismatch, in_ep;
    logic [CW-1:0] n_set, n_reset, n_err;
    logic [1:0]    p;
    logic          ev, chk_fail;
    assign p  = {s_sync[1], r_sync[1]};
    assign ev = p != p_prev;
    // q/notq travel through the same synchronizer depth as s/r, so on an event cycle
    // they may already show the new drive; comparing only on quiet cycles avoids false hits
    assign chk_fail = st == CHECK && !ev && (q_sync[1] != exp_q || nq_sync[1] != ~exp_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= UNKNOWN;
            s_sync   <= '0;
            r_sync   <= '0;
            q_sync   <= '0;
            nq_sync  <= '0;
            p_prev   <= '0;
            cnt      <= '0;
            exp_q    <= 1'b0;
            mismatch <= 1'b0;
            in_ep    <= 1'b0;
            n_set    <= '0;
            n_reset  <= '0;
            n_err    <= '0;
        end else begin
            s_sync  <= {s_sync[0], bus.s};
            r_sync  <= {r_sync[0], bus.r};
            q_sync  <= {q_sync[0], bus.q};
            nq_sync <= {nq_sync[0], bus.notq};
            p_prev  <= p;
            if (ev) begin
                if (p == 2'b11)
                    st <= FORBID;
                else if (p != 2'b00 || st == SETTLE || st == CHECK) begin
                    st  <= SETTLE;
                    cnt <= SW'(SETTLE_CYCLES);
                    if (p != 2'b00)
                        exp_q <= p[1];
                end else
                    st <= UNKNOWN;
            end else if (st == SETTLE) begin
                cnt <= cnt - 1'b1;
                if (cnt == SW'(1))
                    st <= CHECK;
            end
            if (ev && p == 2'b10 && n_set != '1)
                n_set <= n_set + 1'b1;
            if (ev && p == 2'b01 && n_reset != '1)
                n_reset <= n_reset + 1'b1;
            // one error per contiguous run of failing compares
            in_ep <= chk_fail;
            if (chk_fail && !in_ep) begin
                mismatch <= 1'b1;
                if (n_err != '1)
                    n_err <= n_err + 1'b1;
            end
            if (bus.clr) begin
                n_set    <= '0;
                n_reset  <= '0;
                n_err    <= '0;
                mismatch <= 1'b0;
            end
        end
    end
    assign bus.exp_q     = exp_q;
    assign bus.exp_valid = st == SETTLE || st == CHECK;
    assign bus.forbidden = st == FORBID;
    assign bus.mismatch  = mismatch;
    assign bus.n_set     = n_set;
    assign bus.n_reset   = n_reset;
    assign bus.n_err     = n_err;
    assign bus.state     = st;
endmodule
